div_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit by 5-bit `div` datapath. Each requester issues valid/ready dividend/divisor requests. The arbiter grants one request per cycle round-robin, drives the single `div` instance, tracks the in-flight owner, and returns each result into that requester's one-entry response buffer under valid/ready backpressure. Divide-by-zero is detected and flagged, and an issue counter supports bring-up. It sits between the two consumer blocks and the divider core.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div.sv | 51 +++++
 rtl/div_slot.sv | 51 +++++
 rtl/div_arb.sv | 133 +++++++++++++
 tb/tb_div_arb.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the two-requester divider arbiter.
package div_pkg;

  localparam int unsigned A_W  = 8;
  localparam int unsigned B_W  = 5;
  localparam int unsigned NREQ = 2;
  localparam logic [A_W-1:0] DIV0_Q = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    FULL  = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic [A_W-1:0] q;
    logic [B_W-1:0] r;
    logic           err;
  } div_rsp_t;

endpackage

// File: rtl/div.sv
// Single-stage registered 8-bit by 5-bit divider core.
module div
  import div_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_in_valid,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_valid,
  output logic [A_W-1:0] o_q,
  output logic [B_W-1:0] o_r,
  output logic [50:0]    number
);

  localparam logic [50:0] DIV_TRANSISTORS = 51'd2436;

  logic           valid_q;
  logic [A_W-1:0] q_q, q_d;
  logic [B_W-1:0] r_q, r_d;

  // Zero divisor yields zeros here; the arbiter substitutes its own result.
  always_comb begin
    q_d = '0;
    r_d = '0;
    if (i_b != '0) begin
      q_d = i_a / A_W'(i_b);
      r_d = B_W'(i_a % A_W'(i_b));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      valid_q <= i_in_valid;
      if (i_in_valid) begin
        q_q <= q_d;
        r_q <= r_d;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_q     = q_q;
  assign o_r     = r_q;
  assign number  = DIV_TRANSISTORS;

endmodule

// File: rtl/div_slot.sv
// One-entry response buffer with EMPTY/PEND/FULL sequencing for one requester.
module div_slot
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        rsp_ready,
  input  logic        cap_own,
  input  div_rsp_t    cap,
  output slot_state_t state,
  output logic        rsp_valid,
  output div_rsp_t    rsp
);

  slot_state_t state_q, state_d;
  div_rsp_t    rsp_q, rsp_d;
  logic        rsp_valid_q, rsp_valid_d;

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      EMPTY: if (grant) state_d = PEND;
      PEND: begin
        state_d = FULL;
        if (cap_own) rsp_d = cap;
      end
      FULL: if (rsp_ready) state_d = grant ? PEND : EMPTY;
      default: state_d = EMPTY;
    endcase
    rsp_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign state     = state_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp       = rsp_q;

endmodule

// File: rtl/div_arb.sv
// Round-robin arbiter sequencing two requesters onto one shared divider.
module div_arb
  import div_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [A_W-1:0]   req_a0,
  input  logic [A_W-1:0]   req_a1,
  input  logic [B_W-1:0]   req_b0,
  input  logic [B_W-1:0]   req_b1,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [A_W-1:0]   rsp_q0,
  output logic [A_W-1:0]   rsp_q1,
  output logic [B_W-1:0]   rsp_r0,
  output logic [B_W-1:0]   rsp_r1,
  output logic [NREQ-1:0]  rsp_err,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [50:0]      number
);

  slot_state_t    st [NREQ];
  div_rsp_t       rsp [NREQ];
  div_rsp_t       cap;
  logic [NREQ-1:0] elig, gnt;
  logic           sel, any_gnt;
  logic [A_W-1:0] iss_a;
  logic [B_W-1:0] iss_b;
  logic [A_W-1:0] div_q;
  logic [B_W-1:0] div_r;
  logic           div_valid_unused;

  logic             prio_q, prio_d;
  logic             tag_q, tag_d;
  logic             err_pend_q, err_pend_d;
  logic [B_W-1:0]   a_lo_q, a_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A full slot is eligible only if it is being drained this cycle.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      elig[i] = req_valid[i] && (st[i] == EMPTY || (st[i] == FULL && rsp_ready[i]));
    end
    gnt = (&elig) ? (prio_q ? 2'b10 : 2'b01) : elig;
    gnt = gnt & {NREQ{rst_n}};
    sel     = gnt[1];
    any_gnt = |gnt;
    iss_a   = sel ? req_a1 : req_a0;
    iss_b   = sel ? req_b1 : req_b0;
  end

  always_comb begin
    prio_d     = prio_q;
    tag_d      = tag_q;
    err_pend_d = err_pend_q;
    a_lo_d     = a_lo_q;
    cnt_d      = cnt_q + CNT_W'(any_gnt);
    if (any_gnt) begin
      prio_d     = ~sel;
      tag_d      = sel;
      err_pend_d = (iss_b == '0);
      a_lo_d     = iss_a[B_W-1:0];
    end
    cap.q   = err_pend_q ? DIV0_Q : div_q;
    cap.r   = err_pend_q ? a_lo_q : div_r;
    cap.err = err_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      tag_q      <= 1'b0;
      err_pend_q <= 1'b0;
      a_lo_q     <= '0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      tag_q      <= tag_d;
      err_pend_q <= err_pend_d;
      a_lo_q     <= a_lo_d;
      cnt_q      <= cnt_d;
    end
  end

  div u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (any_gnt),
    .i_a        (iss_a),
    .i_b        (iss_b),
    .o_valid    (div_valid_unused),
    .o_q        (div_q),
    .o_r        (div_r),
    .number     (number)
  );

  div_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant     (gnt[0]),
    .rsp_ready (rsp_ready[0]),
    .cap_own   (tag_q == 1'b0),
    .cap       (cap),
    .state     (st[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp       (rsp[0])
  );

  div_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant     (gnt[1]),
    .rsp_ready (rsp_ready[1]),
    .cap_own   (tag_q),
    .cap       (cap),
    .state     (st[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp       (rsp[1])
  );

  assign req_ready = gnt;
  assign rsp_q0    = rsp[0].q;
  assign rsp_q1    = rsp[1].q;
  assign rsp_r0    = rsp[0].r;
  assign rsp_r1    = rsp[1].r;
  assign rsp_err   = {rsp[1].err, rsp[0].err};
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_div_arb.sv
// Directed self-checking bench for div_arb.
module tb_div_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [7:0]  req_a0, req_a1;
  logic [4:0]  req_b0, req_b1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_q0, rsp_q1;
  logic [4:0]  rsp_r0, rsp_r1;
  logic [1:0]  rsp_err;
  logic [15:0] issue_cnt;
  logic [50:0] number;

  int n_checks;
  int n_fail;

  div_arb #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q0    (rsp_q0),
    .rsp_q1    (rsp_q1),
    .rsp_r0    (rsp_r0),
    .rsp_r1    (rsp_r1),
    .rsp_err   (rsp_err),
    .issue_cnt (issue_cnt),
    .number    (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_a0 = 8'd1; req_b0 = 5'd1; req_a1 = 8'd1; req_b1 = 5'd1;
    #3;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_checks++;
    if ({rsp_q0, rsp_q1, rsp_r0, rsp_r1, rsp_err} !== 28'd0) begin
      n_fail++; $display("FAIL reset_rsp_data: got q0=%0d q1=%0d r0=%0d r1=%0d err=%b expected zeros",
                         rsp_q0, rsp_q1, rsp_r0, rsp_r1, rsp_err);
    end
    n_checks++;
    if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_issue_cnt: got %0d expected 0", issue_cnt); end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    req_a0 = 8'd200; req_b0 = 5'd7;
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_pend_valid: got %b expected 00", rsp_valid); end
    n_checks++;
    if (issue_cnt !== 16'd1) begin n_fail++; $display("FAIL single_issue_cnt: got %0d expected 1", issue_cnt); end
    step();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_q0 !== 8'd28 || rsp_r0 !== 5'd4 || rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL single_result: got v=%b q=%0d r=%0d err=%b expected v=01 q=28 r=4 err=00",
                         rsp_valid, rsp_q0, rsp_r0, rsp_err);
    end
    step();
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_consumed: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_r;
    do_reset();
    req_a0 = 8'd255; req_b0 = 5'd31;
    req_a1 = 8'd100; req_b1 = 5'd9;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_r = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (req_ready !== exp_r) begin n_fail++; $display("FAIL contend_grant[%0d]: got %b expected %b", k, req_ready, exp_r); end
      if (k < 2) begin
        n_checks++;
        if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL contend_valid[%0d]: got %b expected 00", k, rsp_valid); end
      end else if (k % 2 == 0) begin
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_q0 !== 8'd8 || rsp_r0 !== 5'd7) begin
          n_fail++; $display("FAIL contend_rsp0[%0d]: got v=%b q=%0d r=%0d expected v=01 q=8 r=7", k, rsp_valid, rsp_q0, rsp_r0);
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 2'b10 || rsp_q1 !== 8'd11 || rsp_r1 !== 5'd1) begin
          n_fail++; $display("FAIL contend_rsp1[%0d]: got v=%b q=%0d r=%0d expected v=10 q=11 r=1", k, rsp_valid, rsp_q1, rsp_r1);
        end
      end
      step();
    end
  endtask

  task automatic test_div_zero;
    do_reset();
    req_a1 = 8'd13; req_b1 = 5'd0;
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL div0_grant: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_q1 !== 8'hFF || rsp_r1 !== 5'd13 || rsp_err !== 2'b10) begin
      n_fail++; $display("FAIL div0_result: got v=%b q=%0d r=%0d err=%b expected v=10 q=255 r=13 err=10",
                         rsp_valid, rsp_q1, rsp_r1, rsp_err);
    end
    req_b1 = 5'd3; req_valid = 2'b10; rsp_ready = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL div0_regrant: got %b expected 10", req_ready); end
    step();
    req_valid = 2'b00; rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL div0_pend: got %b expected 00", rsp_valid); end
    step();
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_q1 !== 8'd4 || rsp_r1 !== 5'd1 || rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL div0_next: got v=%b q=%0d r=%0d err=%b expected v=10 q=4 r=1 err=00",
                         rsp_valid, rsp_q1, rsp_r1, rsp_err);
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] exp_rdy [0:4];
    exp_rdy = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00};
    do_reset();
    req_a0 = 8'd200; req_b0 = 5'd7;
    req_a1 = 8'd100; req_b1 = 5'd9;
    req_valid = 2'b11; rsp_ready = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (req_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy[k]); end
      if (k >= 2) begin
        n_checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_q0 !== 8'd28) begin
          n_fail++; $display("FAIL bp_hold[%0d]: got v0=%b q0=%0d expected v0=1 q0=28", k, rsp_valid[0], rsp_q0);
        end
      end
      step();
    end
    rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01 || rsp_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_consume_grant: got rdy=%b v0=%b expected rdy=01 v0=1", req_ready, rsp_valid[0]);
    end
    step();
    n_checks++;
    if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_bubble: got v0=%b expected 0", rsp_valid[0]); end
    step();
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_q0 !== 8'd28 || rsp_r0 !== 5'd4) begin
      n_fail++; $display("FAIL bp_refill: got v0=%b q0=%0d r0=%0d expected v0=1 q0=28 r0=4", rsp_valid[0], rsp_q0, rsp_r0);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_a1 = 8'd100; req_b1 = 5'd9;
    req_a0 = 8'd200; req_b0 = 5'd7;
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1;
    step();
    req_valid = 2'b01;
    #1;
    step();
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_q1 !== 8'd11) begin
      n_fail++; $display("FAIL mid_pre: got v=%b q1=%0d expected v=10 q1=11", rsp_valid, rsp_q1);
    end
    rst_n = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || issue_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b rdy=%b cnt=%0d expected v=00 rdy=00 cnt=0", rsp_valid, req_ready, issue_cnt);
    end
    n_checks++;
    if ({rsp_q0, rsp_q1, rsp_r0, rsp_r1, rsp_err} !== 28'd0) begin
      n_fail++; $display("FAIL mid_reset_data: got q0=%0d q1=%0d r0=%0d r1=%0d err=%b expected zeros",
                         rsp_q0, rsp_q1, rsp_r0, rsp_r1, rsp_err);
    end
    step();
    rst_n = 1'b1;
    req_valid = 2'b00;
    #1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b expected 00", k, rsp_valid); end
    end
  endtask

  task automatic test_cnt_wrap;
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    do_reset();
    req_a0 = 8'd50; req_b0 = 5'd5;
    req_a1 = 8'd60; req_b1 = 5'd6;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    while (n < 65539 && cyc < 70000) begin
      if (req_ready != 2'b00) n++;
      cyc++;
      step();
    end
    req_valid = 2'b00;
    #1;
    n_checks++;
    if (n != 65539) begin n_fail++; $display("FAIL wrap_budget: got %0d grants expected 65539", n); end
    n_checks++;
    if (issue_cnt !== 16'd3) begin n_fail++; $display("FAIL wrap_issue_cnt: got %0d expected 3", issue_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
